// File: rtl/host_mem_rd_arbiter.sv
// Round-robin arbiter sharing one host-memory Avalon read channel between NUM_REQ requesters.
// Whole bursts are granted, and an in-order tag FIFO steers each response beat back to its owner.

module host_mem_rd_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int TAG_DEPTH       = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_address,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0] req_burstcount,
    input  logic [NUM_REQ-1:0]                 req_read,
    output logic [NUM_REQ-1:0]                 req_waitrequest,
    output logic [DATA_WIDTH-1:0]              req_readdata,
    output logic [NUM_REQ-1:0]                 req_readdatavalid,
    output logic [ADDR_WIDTH-1:0]              hm_address,
    output logic [BURST_CNT_WIDTH-1:0]         hm_burstcount,
    output logic                               hm_read,
    input  logic                               hm_waitrequest,
    input  logic [DATA_WIDTH-1:0]              hm_readdata,
    input  logic                               hm_readdatavalid,
    output logic [$clog2(TAG_DEPTH):0]         outstanding,
    output logic                               err
);

    // state     | meaning
    // ST_OPEN   | no request pending; sel follows the round-robin search
    // ST_LOCKED | a request was stalled by waitrequest; sel pinned to lock_id

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t state, state_nx;

    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            lock_id;
    logic [ID_W-1:0]            sel;
    logic [ID_W-1:0]            sel_open;
    logic [ID_W-1:0]            idx;
    logic                       found;
    logic                       eligible;
    logic                       accept;

    logic [ADDR_WIDTH-1:0]      addr_arr [NUM_REQ];
    logic [BURST_CNT_WIDTH-1:0] bc_arr   [NUM_REQ];

    logic [ID_W-1:0]            tag_id [TAG_DEPTH];
    logic [BURST_CNT_WIDTH-1:0] tag_bc [TAG_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [ID_W-1:0]            head_id;
    logic [BURST_CNT_WIDTH-1:0] head_bc;
    logic [BURST_CNT_WIDTH-1:0] beat_cnt;
    logic                       beat_ok;
    logic                       last_beat;
    logic [NUM_REQ-1:0]         vld_nx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign bc_arr[g]   = req_burstcount[g*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    end

    // First requester at or after rr_ptr, with wrap-around.
    always_comb begin
        sel_open = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_read[idx]) begin
                found    = 1'b1;
                sel_open = idx;
            end
        end
    end

    assign sel      = (state == ST_LOCKED) ? lock_id : sel_open;
    assign eligible = (state == ST_LOCKED) ? req_read[lock_id] : found;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign hm_read = reset_n && eligible && !full;
    assign accept  = hm_read && !hm_waitrequest;

    assign hm_address    = addr_arr[sel];
    assign hm_burstcount = bc_arr[sel];

    always_comb begin
        req_waitrequest = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_waitrequest[i] = !(accept && (sel == ID_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_OPEN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_OPEN:   if (hm_read && hm_waitrequest) state_nx = ST_LOCKED;
            ST_LOCKED: if (accept) state_nx = ST_OPEN;
            default:   state_nx = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_id <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == ST_OPEN && hm_read && hm_waitrequest) begin
                lock_id <= sel;
            end
            if (accept) begin
                rr_ptr <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    // Tag FIFO: one entry per accepted burst, popped on its last response beat.
    assign push      = accept;
    assign head_id   = tag_id[rd_ptr];
    assign head_bc   = tag_bc[rd_ptr];
    assign beat_ok   = hm_readdatavalid && !empty;
    assign last_beat = (head_bc == '0) || (beat_cnt == head_bc - BURST_CNT_WIDTH'(1));
    assign pop       = beat_ok && last_beat;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_id[wr_ptr] <= sel;
            tag_bc[wr_ptr] <= hm_burstcount;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (beat_ok) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        vld_nx = '0;
        if (beat_ok) vld_nx[head_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_readdatavalid <= '0;
            req_readdata      <= '0;
            err               <= 1'b0;
        end else begin
            req_readdatavalid <= vld_nx;
            if (beat_ok) req_readdata <= hm_readdata;
            if ((hm_readdatavalid && empty) || (accept && hm_burstcount == '0)) begin
                err <= 1'b1;
            end
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_host_mem_rd_arbiter.sv
// Scoreboard bench for host_mem_rd_arbiter: directed stimulus queues expected grants and
// response beats; independent monitors compare them when the DUT presents them.

module tb_host_mem_rd_arbiter;

    localparam int NR = 2;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int BW = 6;
    localparam int TD = 4;

    localparam logic [AW-1:0] A0 = 48'h0000_1000_0000;
    localparam logic [AW-1:0] A1 = 48'h0000_2000_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NR*AW-1:0] req_address;
    logic [NR*BW-1:0] req_burstcount;
    logic [NR-1:0] req_read;
    logic [NR-1:0] req_waitrequest;
    logic [DW-1:0] req_readdata;
    logic [NR-1:0] req_readdatavalid;
    logic [AW-1:0] hm_address;
    logic [BW-1:0] hm_burstcount;
    logic          hm_read;
    logic          hm_waitrequest;
    logic [DW-1:0] hm_readdata;
    logic          hm_readdatavalid;
    logic [$clog2(TD):0] outstanding;
    logic          err;

    typedef struct packed {
        logic [0:0]    id;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
    } acc_t;

    typedef struct packed {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] beat_data = 32'hD000_0000;

    host_mem_rd_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_CNT_WIDTH(BW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_burstcount(req_burstcount),
        .req_read(req_read), .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
        .hm_address(hm_address), .hm_burstcount(hm_burstcount),
        .hm_read(hm_read), .hm_waitrequest(hm_waitrequest),
        .hm_readdata(hm_readdata), .hm_readdatavalid(hm_readdatavalid),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_acc(input int id, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        acc_t a;
        a.id = id[0:0];
        a.addr = addr;
        a.bc = bc;
        exp_acc.push_back(a);
    endtask

    // Drive one response beat this cycle and queue its steered copy.
    task automatic beat(input logic [NR-1:0] dest);
        rsp_t r;
        beat_data        = beat_data + 32'h11;
        hm_readdatavalid = 1'b1;
        hm_readdata      = beat_data;
        r.vld  = dest;
        r.data = beat_data;
        exp_rsp.push_back(r);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        req_address[i*AW +: AW]    = addr;
        req_burstcount[i*BW +: BW] = bc;
    endtask

    // Grant monitor.
    initial begin
        acc_t a;
        logic [NR-1:0] wr_exp;
        forever begin
            @(negedge clk);
            if (reset_n && hm_read && !hm_waitrequest) begin
                if (exp_acc.size() == 0) begin
                    n_chk++;
                    $display("FAIL acc_unexpected: got addr %0h bc %0h expected no grant",
                             hm_address, hm_burstcount);
                end else begin
                    a = exp_acc.pop_front();
                    wr_exp = ~(NR'(1) << a.id);
                    check("acc_waitrequest", 64'(req_waitrequest), 64'(wr_exp));
                    check("acc_address", 64'(hm_address), 64'(a.addr));
                    check("acc_burstcount", 64'(hm_burstcount), 64'(a.bc));
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (req_readdatavalid != '0) begin
                if (exp_rsp.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: got vld %0b data %0h expected none",
                             req_readdatavalid, req_readdata);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_valid", 64'(req_readdatavalid), 64'(r.vld));
                    check("rsp_data", 64'(req_readdata), 64'(r.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        req_address      = '0;
        req_burstcount   = '0;
        req_read         = 2'b11;
        hm_waitrequest   = 1'b0;
        hm_readdata      = '0;
        hm_readdatavalid = 1'b0;
        repeat (3) cyc();
        sample();
        check("rst_hm_read", 64'(hm_read), 64'd0);
        check("rst_waitrequest", 64'(req_waitrequest), 64'h3);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdv", 64'(req_readdatavalid), 64'd0);
        check("rst_rdata", 64'(req_readdata), 64'd0);
        cyc();
        req_read = 2'b00;
        reset_n  = 1'b1;

        // Round-robin with both requesting, filling the 4-deep tag FIFO.
        cyc();
        set_req(0, A0, 6'd4);
        set_req(1, A1, 6'd4);
        expect_acc(0, A0, 6'd4);
        expect_acc(1, A1, 6'd4);
        expect_acc(0, A0, 6'd4);
        expect_acc(1, A1, 6'd4);
        req_read = 2'b11;
        repeat (4) cyc();
        sample();
        check("full_hm_read", 64'(hm_read), 64'd0);
        check("full_waitrequest", 64'(req_waitrequest), 64'h3);
        check("full_outstanding", 64'(outstanding), 64'd4);
        for (int k = 0; k < 4; k++) begin
            cyc();
            beat(2'b01);
        end
        sample();
        check("full_last_beat_hm_read", 64'(hm_read), 64'd0);
        cyc();
        hm_readdatavalid = 1'b0;
        expect_acc(0, A0, 6'd4);
        sample();
        check("resume_hm_read", 64'(hm_read), 64'd1);
        cyc();
        req_read = 2'b00;
        sample();
        check("refill_outstanding", 64'(outstanding), 64'd4);
        for (int b = 0; b < 16; b++) begin
            cyc();
            beat(((b / 4) % 2 == 0) ? 2'b10 : 2'b01);
        end
        cyc();
        hm_readdatavalid = 1'b0;
        cyc();
        sample();
        check("drain_outstanding", 64'(outstanding), 64'd0);

        // Response steering: req0 burst 2, req1 burst 3.
        cyc();
        set_req(0, A0 + 48'h40, 6'd2);
        expect_acc(0, A0 + 48'h40, 6'd2);
        req_read = 2'b01;
        cyc();
        set_req(1, A1 + 48'h80, 6'd3);
        expect_acc(1, A1 + 48'h80, 6'd3);
        req_read = 2'b10;
        cyc();
        req_read = 2'b00;
        sample();
        check("steer_outstanding_2", 64'(outstanding), 64'd2);
        for (int k = 0; k < 5; k++) begin
            cyc();
            beat((k < 2) ? 2'b01 : 2'b10);
            sample();
            check("steer_outstanding", 64'(outstanding), (k < 2) ? 64'd2 : 64'd1);
            if (k > 0) check("steer_latency", 64'(req_readdatavalid), (k < 3) ? 64'h1 : 64'h2);
        end
        cyc();
        hm_readdatavalid = 1'b0;
        sample();
        check("steer_latency_last", 64'(req_readdatavalid), 64'h2);
        check("steer_outstanding_0", 64'(outstanding), 64'd0);

        // Lock under waitrequest: rr_ptr is 0, so an unlocked arbiter would switch to req0.
        cyc();
        hm_waitrequest = 1'b1;
        set_req(1, A1 + 48'hC0, 6'd1);
        req_read = 2'b10;
        sample();
        check("lock_hm_read", 64'(hm_read), 64'd1);
        check("lock_addr_c1", 64'(hm_address), 64'(A1 + 48'hC0));
        cyc();
        set_req(0, A0 + 48'h100, 6'd2);
        req_read = 2'b11;
        sample();
        check("lock_addr_c2", 64'(hm_address), 64'(A1 + 48'hC0));
        check("lock_waitrequest", 64'(req_waitrequest), 64'h3);
        cyc();
        sample();
        check("lock_addr_c3", 64'(hm_address), 64'(A1 + 48'hC0));
        cyc();
        hm_waitrequest = 1'b0;
        expect_acc(1, A1 + 48'hC0, 6'd1);
        sample();
        check("lock_addr_accept", 64'(hm_address), 64'(A1 + 48'hC0));
        cyc();
        req_read = 2'b01;
        expect_acc(0, A0 + 48'h100, 6'd2);
        cyc();
        req_read = 2'b00;
        beat(2'b10);
        cyc();
        beat(2'b01);
        cyc();
        beat(2'b01);
        cyc();
        hm_readdatavalid = 1'b0;
        cyc();
        sample();
        check("lock_outstanding_0", 64'(outstanding), 64'd0);
        check("err_clear_before", 64'(err), 64'd0);

        // Response with empty FIFO is dropped and flags err.
        cyc();
        hm_readdatavalid = 1'b1;
        hm_readdata      = 32'hBAD0_0001;
        cyc();
        hm_readdatavalid = 1'b0;
        sample();
        check("err_empty_rsp", 64'(err), 64'd1);
        check("err_empty_no_rdv", 64'(req_readdatavalid), 64'd0);
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        sample();
        check("err_after_reset", 64'(err), 64'd0);

        // Burstcount-0 request: forwarded, flags err, one beat pops it.
        cyc();
        set_req(0, A0 + 48'h200, 6'd0);
        expect_acc(0, A0 + 48'h200, 6'd0);
        req_read = 2'b01;
        cyc();
        req_read = 2'b00;
        sample();
        check("err_bc0", 64'(err), 64'd1);
        check("bc0_outstanding", 64'(outstanding), 64'd1);
        cyc();
        beat(2'b01);
        cyc();
        hm_readdatavalid = 1'b0;
        sample();
        check("bc0_rdv", 64'(req_readdatavalid), 64'h1);
        check("bc0_popped", 64'(outstanding), 64'd0);

        // Reset mid-burst with two bursts outstanding; rr_ptr is 1 beforehand.
        cyc();
        set_req(1, A1 + 48'h240, 6'd2);
        expect_acc(1, A1 + 48'h240, 6'd2);
        req_read = 2'b10;
        cyc();
        set_req(0, A0 + 48'h280, 6'd2);
        expect_acc(0, A0 + 48'h280, 6'd2);
        req_read = 2'b01;
        cyc();
        req_read = 2'b00;
        beat(2'b10);
        cyc();
        hm_readdatavalid = 1'b0;
        reset_n  = 1'b0;
        req_read = 2'b11;
        sample();
        check("midrst_hm_read", 64'(hm_read), 64'd0);
        check("midrst_waitrequest", 64'(req_waitrequest), 64'h3);
        cyc();
        reset_n  = 1'b1;
        req_read = 2'b00;
        sample();
        check("midrst_outstanding", 64'(outstanding), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_rdv", 64'(req_readdatavalid), 64'd0);
        check("midrst_rdata", 64'(req_readdata), 64'd0);
        cyc();
        hm_readdatavalid = 1'b1;
        hm_readdata      = 32'hBAD0_0002;
        cyc();
        hm_readdatavalid = 1'b0;
        sample();
        check("stale_err", 64'(err), 64'd1);
        check("stale_no_rdv", 64'(req_readdatavalid), 64'd0);
        cyc();
        set_req(0, A0 + 48'h300, 6'd1);
        set_req(1, A1 + 48'h300, 6'd1);
        expect_acc(0, A0 + 48'h300, 6'd1);
        req_read = 2'b11;
        cyc();
        req_read = 2'b00;
        beat(2'b01);
        cyc();
        hm_readdatavalid = 1'b0;

        for (int i = 0; i < 50 && (exp_acc.size() != 0 || exp_rsp.size() != 0); i++) cyc();
        check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
